// File: rtl/imem_param.sv
// rtl/imem_param.sv - parametrised instruction memory with handshaked load port and stallable, flushable fetch port
// Load words are written only in LOAD mode; fetch runs only in RUN mode, with SYNC as a one-cycle gap between them.
module imem_param #(
    parameter int              XLEN  = 32,
    parameter int              DEPTH = 1024,
    parameter logic [XLEN-1:0] NOP   = 32'h00000013
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       PROGB,
    input  logic                       PROG_VALID,
    input  logic [XLEN-1:0]            PROG_ADDR,
    input  logic [XLEN-1:0]            PROG_DATA,
    output logic                       PROG_READY,
    output logic [$clog2(DEPTH):0]     PROG_COUNT,
    output logic                       PROG_ERR,
    input  logic                       FETCH_EN,
    input  logic                       FLUSH,
    input  logic [XLEN-1:0]            INSTRUCTION_ADDRESS,
    output logic [XLEN-1:0]            INSTRUCTION,
    output logic                       INST_VALID,
    output logic                       SEGMENTATION_FAULT,
    output logic                       MISALIGNED
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   COUNT_MAX = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_LOAD = 2'd1,
        S_SYNC = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [XLEN-1:0] mem [DEPTH];

    logic          load_aligned;
    logic          load_in_range;
    logic          load_fire;
    logic          load_reject;
    logic [AW-1:0] load_idx;

    logic          fetch_aligned;
    logic          fetch_in_range;
    logic [AW-1:0] fetch_idx;

    logic          entering_load;
    logic          fetch_blocked;

    // In range means every byte-address bit above the word index is zero.
    assign load_aligned   = (PROG_ADDR[1:0] == 2'b00);
    assign load_in_range  = (PROG_ADDR[XLEN-1:AW+2] == '0);
    assign load_idx       = PROG_ADDR[AW+1:2];
    assign load_fire      = (state == S_LOAD) && PROG_VALID && load_aligned && load_in_range;
    assign load_reject    = (state == S_LOAD) && PROG_VALID && !(load_aligned && load_in_range);

    assign fetch_aligned  = (INSTRUCTION_ADDRESS[1:0] == 2'b00);
    assign fetch_in_range = (INSTRUCTION_ADDRESS[XLEN-1:AW+2] == '0);
    assign fetch_idx      = INSTRUCTION_ADDRESS[AW+1:2];

    assign PROG_READY     = (state == S_LOAD);
    assign entering_load  = (state_next == S_LOAD) && (state != S_LOAD);

    // The RUN cycle that leaves for LOAD already presents NOP, so no fetch straddles a load session.
    assign fetch_blocked  = (state != S_RUN) || !PROGB;

    always_comb begin
        state_next = state;
        case (state)
            S_RUN:   if (!PROGB) state_next = S_LOAD;
            S_LOAD:  if (PROGB)  state_next = S_SYNC;
            S_SYNC:  state_next = PROGB ? S_RUN : S_LOAD;
            default: state_next = S_RUN;
        endcase
    end

    // Storage has no reset so that contents survive RST.
    always_ff @(posedge CLK) begin
        if (!RST && load_fire) begin
            mem[load_idx] <= PROG_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state              <= S_RUN;
            PROG_COUNT         <= '0;
            PROG_ERR           <= 1'b0;
            INSTRUCTION        <= NOP;
            INST_VALID         <= 1'b0;
            SEGMENTATION_FAULT <= 1'b0;
            MISALIGNED         <= 1'b0;
        end else begin
            state <= state_next;

            if (entering_load) begin
                PROG_COUNT <= '0;
                PROG_ERR   <= 1'b0;
            end else if (state == S_LOAD) begin
                if (load_fire && (PROG_COUNT != COUNT_MAX)) begin
                    PROG_COUNT <= PROG_COUNT + 1'b1;
                end
                if (load_reject) begin
                    PROG_ERR <= 1'b1;
                end
            end

            if (fetch_blocked || FLUSH) begin
                INSTRUCTION        <= NOP;
                INST_VALID         <= 1'b0;
                SEGMENTATION_FAULT <= 1'b0;
                MISALIGNED         <= 1'b0;
            end else if (FETCH_EN) begin
                MISALIGNED         <= !fetch_aligned;
                SEGMENTATION_FAULT <= !fetch_in_range;
                if (fetch_aligned && fetch_in_range) begin
                    INSTRUCTION <= mem[fetch_idx];
                    INST_VALID  <= 1'b1;
                end else begin
                    INSTRUCTION <= NOP;
                    INST_VALID  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_param.sv
// tb/tb_imem_param.sv - self-checking bench for imem_param
// Expected values come from a word-indexed memory model and the load/fetch rules applied per cycle.
module tb_imem_param;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        progb;
    logic        prog_valid;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        prog_ready;
    logic [10:0] prog_count;
    logic        prog_err;
    logic        fetch_en;
    logic        flush;
    logic [31:0] inst_addr;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        seg_fault;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    logic [31:0] mm [int];
    int          wq [$];
    int          m_count;
    logic        m_err;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_seg;
    logic        e_mis;

    imem_param #(.XLEN(32), .DEPTH(DEPTH), .NOP(NOP)) dut (
        .CLK                 (clk),
        .RST                 (rst),
        .PROGB               (progb),
        .PROG_VALID          (prog_valid),
        .PROG_ADDR           (prog_addr),
        .PROG_DATA           (prog_data),
        .PROG_READY          (prog_ready),
        .PROG_COUNT          (prog_count),
        .PROG_ERR            (prog_err),
        .FETCH_EN            (fetch_en),
        .FLUSH               (flush),
        .INSTRUCTION_ADDRESS (inst_addr),
        .INSTRUCTION         (instruction),
        .INST_VALID          (inst_valid),
        .SEGMENTATION_FAULT  (seg_fault),
        .MISALIGNED          (misaligned)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fetch_model();
        e_instr = NOP;
        e_valid = 1'b0;
        e_seg   = 1'b0;
        e_mis   = 1'b0;
    endtask

    task automatic enter_load();
        progb = 1'b0;
        step();
        m_count = 0;
        m_err   = 1'b0;
        clear_fetch_model();
    endtask

    task automatic exit_load();
        progb = 1'b1;
        step();
        step();
        clear_fetch_model();
    endtask

    // Only meaningful while the memory is in LOAD mode.
    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        prog_valid = 1'b1;
        prog_addr  = a;
        prog_data  = d;
        step();
        prog_valid = 1'b0;
        if (a[1:0] == 2'b00 && a[31:2] < DEPTH) begin
            mm[int'(a[31:2])] = d;
            wq.push_back(int'(a[31:2]));
            if (m_count < DEPTH) m_count++;
        end else begin
            m_err = 1'b1;
        end
    endtask

    // Only meaningful while the memory is in RUN mode.
    task automatic do_fetch(input logic [31:0] a, input logic en, input logic fl);
        inst_addr = a;
        fetch_en  = en;
        flush     = fl;
        step();
        flush     = 1'b0;
        if (fl) begin
            clear_fetch_model();
        end else if (en) begin
            e_mis = (a[1:0] != 2'b00);
            e_seg = (a[31:2] >= DEPTH);
            if (!e_mis && !e_seg) begin
                e_instr = mm[int'(a[31:2])];
                e_valid = 1'b1;
            end else begin
                e_instr = NOP;
                e_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; progb = 1'b1; prog_valid = 1'b0; prog_addr = '0; prog_data = '0;
        fetch_en = 1'b0; flush = 1'b0; inst_addr = '0;
        step();
        step();
        rst = 1'b0;
        clear_fetch_model();
        checks++;
        if (instruction !== 32'h00000013) begin errors++; $display("FAIL reset_instr got %h exp %h", instruction, 32'h00000013); end
        checks++;
        if ({inst_valid, seg_fault, misaligned} !== 3'b000) begin errors++; $display("FAIL reset_fetch_flags got %b exp 000", {inst_valid, seg_fault, misaligned}); end
        checks++;
        if ({prog_ready, prog_err} !== 2'b00) begin errors++; $display("FAIL reset_prog_flags got %b exp 00", {prog_ready, prog_err}); end
        checks++;
        if (prog_count !== 11'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", prog_count); end
    endtask

    task automatic test_load_session();
        enter_load();
        checks++;
        if (prog_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b exp 1", prog_ready); end
        load_word(32'h0, 32'hAAAA0001);
        load_word(32'h4, 32'hBBBB0002);
        load_word(32'hFFC, 32'hCCCC0003);
        checks++;
        if (prog_count !== 11'd3 || prog_err !== 1'b0) begin errors++; $display("FAIL load_count got %0d/%b exp 3/0", prog_count, prog_err); end
        exit_load();
        checks++;
        if (prog_ready !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL load_exit got %b/%b exp 0/0", prog_ready, inst_valid); end
        do_fetch(32'h4, 1'b1, 1'b0);
        checks++;
        if (instruction !== 32'hBBBB0002 || inst_valid !== 1'b1) begin errors++; $display("FAIL load_fetch got %h/%b exp bbbb0002/1", instruction, inst_valid); end
    endtask

    task automatic test_bad_load();
        enter_load();
        load_word(32'h8, 32'h11110004);
        load_word(32'h1000, 32'hDEAD0001);
        checks++;
        if (prog_err !== 1'b1 || prog_count !== 11'd1) begin errors++; $display("FAIL bad_oor got %b/%0d exp 1/1", prog_err, prog_count); end
        load_word(32'h6, 32'hDEAD0002);
        checks++;
        if (prog_err !== 1'b1 || prog_count !== 11'd1) begin errors++; $display("FAIL bad_mis got %b/%0d exp 1/1", prog_err, prog_count); end
        exit_load();
        do_fetch(32'h8, 1'b1, 1'b0);
        checks++;
        if (instruction !== 32'h11110004) begin errors++; $display("FAIL bad_new_word got %h exp 11110004", instruction); end
        do_fetch(32'h0, 1'b1, 1'b0);
        checks++;
        if (instruction !== 32'hAAAA0001) begin errors++; $display("FAIL bad_intact0 got %h exp aaaa0001", instruction); end
        do_fetch(32'h4, 1'b1, 1'b0);
        checks++;
        if (instruction !== 32'hBBBB0002) begin errors++; $display("FAIL bad_intact4 got %h exp bbbb0002", instruction); end
        do_fetch(32'hFFC, 1'b1, 1'b0);
        checks++;
        if (instruction !== 32'hCCCC0003) begin errors++; $display("FAIL bad_intact_top got %h exp cccc0003", instruction); end
    endtask

    task automatic test_fetch_faults();
        do_fetch(32'h1000, 1'b1, 1'b0);
        checks++;
        if ({seg_fault, misaligned, inst_valid} !== 3'b100 || instruction !== NOP) begin errors++; $display("FAIL fault_seg got %b %h exp 100 %h", {seg_fault, misaligned, inst_valid}, instruction, NOP); end
        do_fetch(32'h2, 1'b1, 1'b0);
        checks++;
        if ({seg_fault, misaligned, inst_valid} !== 3'b010 || instruction !== NOP) begin errors++; $display("FAIL fault_mis got %b %h exp 010 %h", {seg_fault, misaligned, inst_valid}, instruction, NOP); end
        do_fetch(32'h1002, 1'b1, 1'b0);
        checks++;
        if ({seg_fault, misaligned, inst_valid} !== 3'b110) begin errors++; $display("FAIL fault_both got %b exp 110", {seg_fault, misaligned, inst_valid}); end
        do_fetch(32'h0, 1'b1, 1'b0);
        checks++;
        if ({seg_fault, misaligned, inst_valid} !== 3'b001 || instruction !== 32'hAAAA0001) begin errors++; $display("FAIL fault_clear got %b %h exp 001 aaaa0001", {seg_fault, misaligned, inst_valid}, instruction); end
    endtask

    task automatic test_stall_flush();
        do_fetch(32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'h4, 1'b0, 1'b0);
            checks++;
            if (instruction !== 32'hAAAA0001 || inst_valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got %h/%b exp aaaa0001/1", i, instruction, inst_valid); end
        end
        do_fetch(32'h4, 1'b0, 1'b1);
        checks++;
        if (instruction !== NOP || inst_valid !== 1'b0) begin errors++; $display("FAIL flush_stall got %h/%b exp %h/0", instruction, inst_valid, NOP); end
        do_fetch(32'h1000, 1'b1, 1'b0);
        do_fetch(32'h1000, 1'b0, 1'b0);
        checks++;
        if (seg_fault !== 1'b1) begin errors++; $display("FAIL stall_fault_hold got %b exp 1", seg_fault); end
        do_fetch(32'h1000, 1'b1, 1'b1);
        checks++;
        if (seg_fault !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL flush_fault got %b/%b exp 0/0", seg_fault, inst_valid); end
    endtask

    task automatic test_mode_toggle();
        int pulses;
        pulses = 0;
        do_fetch(32'h0, 1'b1, 1'b0);
        progb = 1'b0;
        step();
        m_count = 0; m_err = 1'b0;
        pulses += int'(prog_ready);
        checks++;
        if (inst_valid !== 1'b0 || instruction !== NOP) begin errors++; $display("FAIL toggle_leave got %b %h exp 0 %h", inst_valid, instruction, NOP); end
        progb = 1'b1;
        step();
        pulses += int'(prog_ready);
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL toggle_sync_entry got %b exp 0", inst_valid); end
        step();
        pulses += int'(prog_ready);
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL toggle_sync_gap got %b exp 0", inst_valid); end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL toggle_ready_pulses got %0d exp 1", pulses); end
        do_fetch(32'h0, 1'b1, 1'b0);
        checks++;
        if (inst_valid !== 1'b1 || instruction !== 32'hAAAA0001) begin errors++; $display("FAIL toggle_resume got %b %h exp 1 aaaa0001", inst_valid, instruction); end
    endtask

    task automatic test_reset_mid_load();
        enter_load();
        load_word(32'h10, 32'h5A5A0010);
        load_word(32'h13, 32'hDEAD0013);
        checks++;
        if (prog_count !== 11'd1 || prog_err !== 1'b1) begin errors++; $display("FAIL rml_pre got %0d/%b exp 1/1", prog_count, prog_err); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (prog_count !== 11'd0 || prog_err !== 1'b0 || prog_ready !== 1'b0) begin errors++; $display("FAIL rml_reset got %0d/%b/%b exp 0/0/0", prog_count, prog_err, prog_ready); end
        step();
        m_count = 0; m_err = 1'b0;
        checks++;
        if (prog_ready !== 1'b1 || prog_count !== 11'd0) begin errors++; $display("FAIL rml_reenter got %b/%0d exp 1/0", prog_ready, prog_count); end
        exit_load();
        do_fetch(32'h10, 1'b1, 1'b0);
        checks++;
        if (instruction !== 32'h5A5A0010) begin errors++; $display("FAIL rml_intact got %h exp 5a5a0010", instruction); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int r;
        enter_load();
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      a = {20'd0, 10'($urandom_range(256, 511)), 2'b00};
            else if (r < 8) a = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
            else            a = {30'($urandom_range(DEPTH, 30'h3FFF_FFFF)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) begin
                prog_addr = a;
                step();
            end else begin
                load_word(a, $urandom);
            end
            checks++;
            if (int'(prog_count) !== m_count || prog_err !== m_err) begin errors++; $display("FAIL rand_load%0d got %0d/%b exp %0d/%b", i, prog_count, prog_err, m_count, m_err); end
        end
        exit_load();
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)      a = {20'd0, 10'(wq[$urandom_range(0, wq.size() - 1)]), 2'b00};
            else if (r < 8) a = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
            else            a = {30'($urandom_range(DEPTH, 30'h3FFF_FFFF)), 2'($urandom_range(0, 3))};
            do_fetch(a, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
            checks++;
            if ({instruction, inst_valid, seg_fault, misaligned} !== {e_instr, e_valid, e_seg, e_mis}) begin
                errors++;
                $display("FAIL rand_fetch%0d addr %h got %h %b%b%b exp %h %b%b%b", i, a, instruction, inst_valid, seg_fault, misaligned, e_instr, e_valid, e_seg, e_mis);
            end
        end
    endtask

    task automatic test_count_saturate();
        enter_load();
        for (int i = 0; i < DEPTH + 2; i++) begin
            load_word({20'd0, 10'(i % DEPTH), 2'b00}, $urandom);
        end
        checks++;
        if (prog_count !== 11'd1024 || int'(prog_count) !== m_count) begin errors++; $display("FAIL sat_count got %0d exp %0d", prog_count, m_count); end
        exit_load();
        do_fetch(32'h3FC, 1'b1, 1'b0);
        checks++;
        if (instruction !== e_instr || inst_valid !== 1'b1) begin errors++; $display("FAIL sat_fetch got %h/%b exp %h/1", instruction, inst_valid, e_instr); end
    endtask

    initial begin
        test_reset();
        test_load_session();
        test_bad_load();
        test_fetch_faults();
        test_stall_flush();
        test_mode_toggle();
        test_reset_mid_load();
        test_random();
        test_count_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_param.md
# imem_param

Parametrised, synchronous instruction memory with a handshaked load port and a stallable, flushable fetch port. It replaces the fixed 1024×32 instruction store at the front of the pipeline's IF stage. It also adds load sequencing, bounds and alignment checking, and fault reporting. The core fetches from it in RUN mode; a boot loader or host writes it in LOAD mode.

## Interface
Parameters:
- XLEN, 32: instruction and address width.
- DEPTH, 1024: number of words; must be a power of two. AW = $clog2(DEPTH).
- NOP, 32'h00000013: value driven on INSTRUCTION whenever no valid instruction is presented.

Ports:
- CLK  in  1  single clock, all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- PROGB  in  1  low = request LOAD mode, high = request RUN mode.
- PROG_VALID  in  1  load word offered.
- PROG_ADDR  in  XLEN  byte address of the load word.
- PROG_DATA  in  XLEN  load word.
- PROG_READY  out  1  load port accepting words.
- PROG_COUNT  out  AW+1  number of words accepted in the current load session.
- PROG_ERR  out  1  sticky flag: a load word was rejected.
- FETCH_EN  in  1  high = advance fetch, low = stall.
- FLUSH  in  1  kill the fetch output.
- INSTRUCTION_ADDRESS  in  XLEN  fetch byte address.
- INSTRUCTION  out  XLEN  fetched word.
- INST_VALID  out  1  INSTRUCTION is a real fetched word.
- SEGMENTATION_FAULT  out  1  last fetch address was out of range.
- MISALIGNED  out  1  last fetch address was not word-aligned.

## Operation
- Storage: DEPTH×XLEN array. Word index = address[AW+1:2]. An address is in range iff address[XLEN-1:2] < DEPTH. Memory contents are not cleared by RST.
- FSM states: S_RUN, S_LOAD, S_SYNC. Reset state is S_RUN.
  - S_RUN & !PROGB → S_LOAD.
  - S_LOAD & PROGB → S_SYNC.
  - S_SYNC & PROGB → S_RUN.
  - S_SYNC & !PROGB → S_LOAD.
- PROG_READY = (state == S_LOAD).
- A load word is accepted iff PROG_READY & PROG_VALID & PROG_ADDR[1:0]==0 & PROG_ADDR in range. An accepted word is written at the word index and increments PROG_COUNT. PROG_COUNT saturates at DEPTH.
- PROG_VALID with a bad address in S_LOAD: no write; PROG_ERR ← 1.
- On any transition into S_LOAD, PROG_COUNT ← 0 and PROG_ERR ← 0.
- Fetch happens only in S_RUN. Per cycle, highest priority first:
  - FLUSH: INSTRUCTION ← NOP, INST_VALID ← 0, both fault flags ← 0.
  - !FETCH_EN: all fetch outputs hold their values.
  - Misaligned address (address[1:0] != 0): MISALIGNED ← 1, INSTRUCTION ← NOP, INST_VALID ← 0.
  - Out-of-range address: SEGMENTATION_FAULT ← 1, INSTRUCTION ← NOP, INST_VALID ← 0. If the address is both misaligned and out of range, both flags are set.
  - Otherwise: INSTRUCTION ← mem[index], INST_VALID ← 1, both flags ← 0.
- Fault flags are not sticky; they describe the most recent completed fetch.
- In S_LOAD and S_SYNC, and in the S_RUN cycle that leaves for S_LOAD: INSTRUCTION ← NOP, INST_VALID ← 0, both fault flags ← 0.

## Timing
- Reset values of all outputs:
  - INSTRUCTION = NOP.
  - INST_VALID, SEGMENTATION_FAULT, MISALIGNED, PROG_READY, PROG_ERR = 0.
  - PROG_COUNT = 0.
- Fetch latency is 1 cycle: an address presented at edge N yields INSTRUCTION/INST_VALID after edge N+1.
- Load write takes effect at the accepting edge.
- A word written at edge N is readable by the first fetch in S_RUN. That fetch is at least 2 edges later, because S_SYNC guarantees a one-cycle gap and there is no read-during-write bypass.
- PROGB falling: PROG_READY is high 1 cycle after the edge at which PROGB is sampled low.
- PROGB rising while in S_LOAD: a PROG_VALID in that same cycle is still accepted, since the state is still S_LOAD.
- RST asserted mid-load: the state returns to S_RUN and PROG_COUNT and PROG_ERR clear. Words already written remain in memory. If PROGB is still low, the FSM re-enters S_LOAD on the next edge.
- FLUSH and FETCH_EN=0 in the same cycle: the flush wins.

## Test plan
- Reset with PROGB=1: all outputs at reset values; INSTRUCTION=32'h00000013.
- Load session:
  - Drive PROGB=0, then write 0xAAAA0001@0x0, 0xBBBB0002@0x4, 0xCCCC0003@0xFFC → PROG_COUNT=3, PROG_ERR=0.
  - Drive PROGB=1 and fetch 0x4 → INSTRUCTION=0xBBBB0002, INST_VALID=1, one cycle after the address.
- Bad load words: PROG_ADDR=0x1000 (DEPTH=1024) or 0x6 → no write, PROG_ERR=1, PROG_COUNT unchanged, prior contents intact.
- Fetch faults:
  - Fetch 0x1000 → SEGMENTATION_FAULT=1, INST_VALID=0, INSTRUCTION=NOP.
  - Fetch 0x2 → MISALIGNED=1, INST_VALID=0.
  - Next fetch of 0x0 clears both flags and returns 0xAAAA0001.
- Stall and flush:
  - Fetch 0x0, then FETCH_EN=0 while the address changes to 0x4 → INSTRUCTION holds 0xAAAA0001 for the whole stall.
  - FLUSH=1 with FETCH_EN=0 → INSTRUCTION=NOP, INST_VALID=0.
- Mode switches:
  - Toggle PROGB low for one cycle → PROG_READY pulses once, S_SYNC is visited before S_RUN, INST_VALID=0 throughout.
  - Assert RST during S_LOAD with PROGB held low → PROG_COUNT=0, PROG_READY=0 for one cycle, then PROG_READY=1 again.
